// File: rtl/sec_encoder_pipe.sv
// sec_encoder_pipe: pipelined Hamming SEC encoder with valid/ready flow control, fault-injection hook and saturating word counter.
// Define SEC_DED_EN to append an even overall-parity bit (SEC-DED codeword).
module sec_encoder_pipe #(
  parameter int DATA_W      = 128,
  parameter int PIPE_STAGES = 2,
  parameter int CNT_W       = 32,
  localparam int R0         = $clog2(DATA_W + 1),
  localparam int R1         = $clog2(DATA_W + R0 + 1),
  localparam int PAR_W      = $clog2(DATA_W + R1 + 1),
  localparam int HAM_W      = DATA_W + PAR_W,
`ifdef SEC_DED_EN
  localparam int CODE_W     = HAM_W + 1,
`else
  localparam int CODE_W     = HAM_W,
`endif
  localparam int POS_W      = $clog2(CODE_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              inj_en,
  input  logic [POS_W-1:0]  inj_pos,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic [CNT_W-1:0]  word_cnt
);
  // Data bits walk out of d in order into the non-power-of-two positions, each folding into the check bits its position selects.
  function automatic logic [CODE_W-1:0] build(input logic [DATA_W-1:0] d, input logic [CODE_W-1:0] m);
    logic [HAM_W-1:0] c;
    logic [DATA_W-1:0] r;
    c = '0;
    r = d;
    for (int p = 1; p <= HAM_W; p++)
      if ((p & (p - 1)) != 0) begin
        c[p-1] = r[0];
        for (int k = 0; k < PAR_W; k++)
          if (p[k]) c[(1 << k) - 1] = c[(1 << k) - 1] ^ r[0];
        r = r >> 1;
      end
`ifdef SEC_DED_EN
    return {^c, c} ^ m;
`else
    return c ^ m;
`endif
  endfunction
  logic [CODE_W-1:0] inj_mask;
  logic              out_valid_q, out_load;
  logic [CODE_W-1:0] out_code_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  assign inj_mask = (inj_en && 32'(inj_pos) < CODE_W) ? CODE_W'(1) << inj_pos : '0;
  assign out_load = ~out_valid_q | out_ready;
  assign out_valid = out_valid_q;
  assign out_code = out_code_q;
  assign word_cnt = cnt_q;
  generate
    if (PIPE_STAGES == 1) begin : g_one
      assign in_ready = out_load;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          out_valid_q <= 1'b0;
          out_code_q  <= '0;
        end else if (out_load) begin
          out_valid_q <= in_valid;
          if (in_valid) out_code_q <= build(in_data, inj_mask);
        end
    end else begin : g_two
      logic              s1_valid_q;
      logic [DATA_W-1:0] s1_data_q;
      logic [CODE_W-1:0] s1_mask_q;
      assign in_ready = ~s1_valid_q | (s1_valid_q & out_load);
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          s1_valid_q  <= 1'b0;
          s1_data_q   <= '0;
          s1_mask_q   <= '0;
          out_valid_q <= 1'b0;
          out_code_q  <= '0;
        end else begin
          if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
              s1_data_q <= in_data;
              s1_mask_q <= inj_mask;
            end
          end
          if (out_load) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) out_code_q <= build(s1_data_q, s1_mask_q);
          end
        end
    end
  endgenerate
  always_comb cnt_d = (out_valid_q & out_ready & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: tb/tb_sec_encoder_pipe.sv
// tb_sec_encoder_pipe: directed and streamed checks of sec_encoder_pipe (DATA_W=128, PIPE_STAGES=2, pure SEC).
module tb_sec_encoder_pipe;
  localparam int DW = 128;
  localparam int CW = 136;
  logic          clk = 1'b0, rst_n = 1'b0;
  logic          in_valid = 1'b0, in_ready, inj_en = 1'b0, out_valid, out_ready = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic [7:0]    inj_pos = '0;
  logic [CW-1:0] out_code, e, prev_code;
  logic [31:0]   word_cnt;
  logic [CW-1:0] exp_q[$];
  int            checks = 0, failures = 0, exp_cnt = 0;
  bit            prev_stall = 0, rnd = 0;
  sec_encoder_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .inj_en(inj_en), .inj_pos(inj_pos), .out_valid(out_valid), .out_ready(out_ready),
    .out_code(out_code), .word_cnt(word_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(string nm, logic [255:0] a, logic [255:0] x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, a, x);
    end
  endtask
  // Check bits come from the syndrome: XOR of the positions of every set data bit.
  function automatic logic [CW-1:0] model(logic [DW-1:0] d, logic ie, logic [7:0] ip);
    logic [CW-1:0] c;
    int syn, j;
    c = '0;
    syn = 0;
    j = 0;
    for (int p = 1; p <= CW; p++)
      if ((p & (p - 1)) != 0) begin
        if (d[j]) begin
          c[p-1] = 1'b1;
          syn ^= p;
        end
        j++;
      end
    for (int k = 0; k < 8; k++) c[(1 << k) - 1] = syn[k];
    if (ie && int'(ip) < CW) c[ip] = ~c[ip];
    return c;
  endfunction
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_cnt = 0;
      prev_stall = 0;
    end else begin
      chk("word_cnt", word_cnt, exp_cnt);
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_code", out_code, prev_code);
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_data, inj_en, inj_pos));
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL spurious_word got=%0h want=none", out_code);
        end else begin
          e = exp_q.pop_front();
          if (out_code !== e) begin
            failures++;
            $display("FAIL stream_code got=%0h want=%0h", out_code, e);
          end
        end
        exp_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_code = out_code;
    end
  end
  task automatic single(string nm, logic [DW-1:0] d, logic ie, logic [7:0] ip, logic [CW-1:0] x);
    int n;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = d;
    inj_en = ie;
    inj_pos = ip;
    @(posedge clk); #1;
    in_valid = 1'b0;
    inj_en = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_lat"}, n, 2);
    chk({nm, "_code"}, out_code, x);
    @(posedge clk); #1;
  endtask
  task automatic send(logic [DW-1:0] d);
    bit a;
    int n;
    in_valid = 1'b1;
    in_data = d;
    n = 0;
    do begin
      @(negedge clk);
      a = in_ready;
      @(posedge clk); #1;
      n++;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
    end while (!a && n < 50);
    in_valid = 1'b0;
    if (!a) chk("send_timeout", 1, 0);
  endtask
  initial begin
    int n;
    #3;
    chk("rst_valid", out_valid, 0);
    chk("rst_cnt", word_cnt, 0);
    chk("rst_code", out_code, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rdy_after_rst", in_ready, 1);
    single("t1_zero", '0, 0, 0, '0);
    chk("t1_cnt", word_cnt, 1);
    single("t2_one", 128'd1, 0, 0, 136'h7);
    e = '0; e[7] = 1'b1; e[127] = 1'b1; e[135] = 1'b1;
    single("t3_msb", {1'b1, 127'd0}, 0, 0, e);
    e = '0; e[40] = 1'b1;
    single("t5_inj40", '0, 1, 40, e);
    single("t5_inj200", '0, 1, 200, '0);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    rnd = 1;
    for (int i = 0; i < 16; i++) send({$urandom, $urandom, $urandom, $urandom});
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    rnd = 0;
    out_ready = 1'b1;
    chk("t4_drained", exp_q.size(), 0);
    chk("t4_cnt", word_cnt, 16);
    out_ready = 1'b0;
    send(128'hA5);
    send(128'h5A);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", out_valid, 0);
    chk("t6_cnt", word_cnt, 0);
    chk("t6_code", out_code, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    chk("t6_rdy", in_ready, 1);
    single("t6_after", 128'd2, 0, 0, 136'h19);
    chk("t6_cnt_after", word_cnt, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end
endmodule
